// File: rtl/tick_irq_gen.sv
// Multi-channel programmable tick and interrupt generator: per-channel period counter,
// periodic or one-shot mode, pending latch with level acknowledge, and overrun flag.
module tick_irq_gen #(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = 24,
    parameter int               DEFAULT_DIV = 40000,
    parameter logic [15:0]      RESET_EN    = 16'h0001,
    parameter int               CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic                cfg_en,
    input  logic                cfg_oneshot,
    input  logic [N_CH-1:0]     ack,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     pending,
    output logic [N_CH-1:0]     overrun,
    output logic [N_CH-1:0]     enabled,
    output logic                irq_any
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_DIV - 32'd1);

    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [N_CH-1:0]  oneshot_q, oneshot_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  overrun_q, overrun_d;
    logic             irq_any_q, irq_any_d;
    logic [N_CH-1:0]  term_s;
    logic [N_CH-1:0]  sel_s;
    logic             cfg_ok_s;

    // Next-state for every channel: counting, one-shot disarm, config write, irq latches.
    always_comb begin
        cfg_ok_s  = cfg_we && (32'(cfg_ch) < 32'(N_CH));
        term_s    = {N_CH{1'b0}};
        sel_s     = {N_CH{1'b0}};
        oneshot_d = oneshot_q;
        en_d      = en_q;
        tick_d    = {N_CH{1'b0}};
        pending_d = {N_CH{1'b0}};
        overrun_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            term_s[i]   = en_q[i] && (cnt_q[i] == period_q[i]);
            sel_s[i]    = cfg_ok_s && (32'(cfg_ch) == 32'(i));

            if (term_s[i]) begin
                cnt_d[i] = CNT_ZERO;
                if (oneshot_q[i]) begin
                    en_d[i] = 1'b0;
                end else begin
                    en_d[i] = en_q[i];
                end
            end else if (en_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            // A write wins over the counter update but the terminal event is still reported.
            if (sel_s[i]) begin
                cnt_d[i]     = CNT_ZERO;
                period_d[i]  = cfg_period;
                en_d[i]      = cfg_en;
                oneshot_d[i] = cfg_oneshot;
            end else begin
                period_d[i]  = period_q[i];
                oneshot_d[i] = oneshot_q[i];
            end

            tick_d[i]    = term_s[i];
            pending_d[i] = ~ack[i] & (term_s[i] | pending_q[i]);
            overrun_d[i] = ~ack[i] & (overrun_q[i] | (term_s[i] & pending_q[i]));
        end
        irq_any_d = |pending_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= CNT_ZERO;
                period_q[i] <= RST_PERIOD;
            end
            oneshot_q <= {N_CH{1'b0}};
            en_q      <= RESET_EN[N_CH-1:0];
            tick_q    <= {N_CH{1'b0}};
            pending_q <= {N_CH{1'b0}};
            overrun_q <= {N_CH{1'b0}};
            irq_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
            oneshot_q <= oneshot_d;
            en_q      <= en_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_any_q <= irq_any_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pending_q;
    assign overrun = overrun_q;
    assign enabled = en_q;
    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_tick_irq_gen.sv
// Scoreboard bench for tick_irq_gen: stimulus pushes expected tick cycles and state
// snapshots; a negedge monitor pops and compares them against the DUT outputs.
module tb_tick_irq_gen;

    logic        clk_s = 1'b0;
    logic        reset_n_s;
    logic        cfg_we_s;
    logic [2:0]  cfg_ch_s;
    logic [23:0] cfg_period_s;
    logic        cfg_en_s;
    logic        cfg_oneshot_s;
    logic [3:0]  ack_s;
    logic [3:0]  tick_s;
    logic [3:0]  pending_s;
    logic [3:0]  overrun_s;
    logic [3:0]  enabled_s;
    logic        irq_any_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en_r = 1'b0;

    typedef struct {
        int         cyc;
        int         kind;   // 0 pending, 1 overrun, 2 enabled, 3 irq_any
        logic [3:0] mask;
        logic [3:0] val;
    } st_t;

    int  tq [4][$];
    st_t sq [$];

    tick_irq_gen #(
        .N_CH(4), .CNT_W(24), .DEFAULT_DIV(40000), .RESET_EN(16'h0001), .CH_W(3)
    ) dut (
        .clk(clk_s), .reset_n(reset_n_s), .cfg_we(cfg_we_s), .cfg_ch(cfg_ch_s),
        .cfg_period(cfg_period_s), .cfg_en(cfg_en_s), .cfg_oneshot(cfg_oneshot_s),
        .ack(ack_s), .tick(tick_s), .pending(pending_s), .overrun(overrun_s),
        .enabled(enabled_s), .irq_any(irq_any_s)
    );

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    // Absolute edge counter used to timestamp every expectation.
    always @(posedge clk_s) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            0:       return "pending";
            1:       return "overrun";
            2:       return "enabled";
            3:       return "irq_any";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: tick events pop per-channel queues; scheduled state snapshots are compared.
    always @(negedge clk_s) begin
        if (mon_en_r) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (tick_s[ch] === 1'b1) begin
                    checks++;
                    if (tq[ch].size() == 0) begin
                        errors++;
                        $display("FAIL tick_unexpected ch%0d cyc %0d: got tick=1, want 0", ch, cyc);
                    end else begin
                        int f;
                        f = tq[ch].pop_front();
                        if (f != cyc) begin
                            errors++;
                            $display("FAIL tick_time ch%0d: got tick at cyc %0d, want cyc %0d", ch, cyc, f);
                        end
                    end
                end else if (tq[ch].size() > 0 && tq[ch][0] <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_missing ch%0d: got tick=%b at cyc %0d, want 1", ch, tick_s[ch], cyc);
                    void'(tq[ch].pop_front());
                end
            end
            for (int k = sq.size() - 1; k >= 0; k--) begin
                if (sq[k].cyc == cyc) begin
                    logic [3:0] got;
                    case (sq[k].kind)
                        0:       got = pending_s;
                        1:       got = overrun_s;
                        2:       got = enabled_s;
                        3:       got = {3'b000, irq_any_s};
                        default: got = 4'bxxxx;
                    endcase
                    checks++;
                    if ((got & sq[k].mask) !== (sq[k].val & sq[k].mask)) begin
                        errors++;
                        $display("FAIL %s cyc %0d: got %b, want %b (mask %b)",
                                 kind_name(sq[k].kind), cyc, got, sq[k].val, sq[k].mask);
                    end
                    sq.delete(k);
                end
            end
        end
    end

    task automatic push_st(input int c, input int kind, input logic [3:0] mask, input logic [3:0] val);
        st_t e;
        e.cyc = c; e.kind = kind; e.mask = mask; e.val = val;
        sq.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_s);
    endtask

    task automatic write_cfg(input int ch, input int p, input logic en, input logic os, output int w);
        cfg_we_s      = 1'b1;
        cfg_ch_s      = 3'(ch);
        cfg_period_s  = 24'(p);
        cfg_en_s      = en;
        cfg_oneshot_s = os;
        w = cyc + 1;
        @(negedge clk_s);
        cfg_we_s = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w2, w1, w3, rr, dummy;
        reset_n_s = 1'b0; cfg_we_s = 1'b0; cfg_ch_s = 3'd0; cfg_period_s = 24'd0;
        cfg_en_s = 1'b0; cfg_oneshot_s = 1'b0; ack_s = 4'b0000;
        repeat (3) @(negedge clk_s);
        reset_n_s = 1'b1;
        r0 = cyc;
        mon_en_r = 1'b1;
        push_st(r0 + 1, 0, 4'b1111, 4'b0000);
        push_st(r0 + 1, 1, 4'b1111, 4'b0000);
        push_st(r0 + 1, 2, 4'b1111, 4'b0001);
        push_st(r0 + 1, 3, 4'b0001, 4'b0000);
        wait_until(r0 + 2);

        // Periodic ch2, period 4; reconfigured to period 7 on its terminal cycle.
        write_cfg(2, 4, 1'b1, 1'b0, w2);
        foreach (tq[0][i]) ;
        tq[2].push_back(w2 + 5);  tq[2].push_back(w2 + 10); tq[2].push_back(w2 + 15);
        tq[2].push_back(w2 + 20); tq[2].push_back(w2 + 28); tq[2].push_back(w2 + 36);
        push_st(w2 + 5,  0, 4'b0100, 4'b0100);
        push_st(w2 + 5,  1, 4'b0100, 4'b0000);
        push_st(w2 + 5,  3, 4'b0001, 4'b0001);
        push_st(w2 + 10, 1, 4'b0100, 4'b0100);
        push_st(w2 + 12, 0, 4'b0100, 4'b0000);
        push_st(w2 + 12, 1, 4'b0100, 4'b0000);
        push_st(w2 + 12, 3, 4'b0001, 4'b0000);
        push_st(w2 + 15, 0, 4'b0100, 4'b0100);
        push_st(w2 + 15, 1, 4'b0100, 4'b0000);
        push_st(w2 + 20, 1, 4'b0100, 4'b0100);
        wait_until(w2 + 11);
        ack_s = 4'b0100;
        @(negedge clk_s);
        ack_s = 4'b0000;
        wait_until(w2 + 19);
        write_cfg(2, 7, 1'b1, 1'b0, dummy);
        // Out-of-range channel must leave every channel untouched.
        wait_until(w2 + 24);
        write_cfg(5, 0, 1'b1, 1'b1, dummy);
        push_st(w2 + 26, 2, 4'b1111, 4'b0101);
        wait_until(w2 + 37);
        write_cfg(2, 7, 1'b0, 1'b0, dummy);
        push_st(w2 + 38, 2, 4'b1111, 4'b0001);
        push_st(w2 + 38, 0, 4'b0100, 4'b0100);
        push_st(w2 + 38, 1, 4'b0100, 4'b0100);

        // One-shot ch1, period 9.
        wait_until(w2 + 45);
        write_cfg(1, 9, 1'b1, 1'b1, w1);
        tq[1].push_back(w1 + 10);
        push_st(w1 + 9,  2, 4'b0010, 4'b0010);
        push_st(w1 + 10, 2, 4'b0010, 4'b0000);
        push_st(w1 + 10, 0, 4'b0010, 4'b0010);
        wait_until(w1 + 110);

        // ch3 period 0 with ack held, then released.
        ack_s = 4'b1000;
        write_cfg(3, 0, 1'b1, 1'b0, w3);
        for (int k = 1; k <= 8; k++) tq[3].push_back(w3 + k);
        push_st(w3 + 1, 0, 4'b1000, 4'b0000);
        push_st(w3 + 3, 0, 4'b1000, 4'b0000);
        push_st(w3 + 5, 0, 4'b1000, 4'b1000);
        push_st(w3 + 5, 1, 4'b1000, 4'b0000);
        push_st(w3 + 6, 1, 4'b1000, 4'b1000);
        wait_until(w3 + 4);
        ack_s = 4'b0000;
        wait_until(w3 + 7);
        write_cfg(3, 0, 1'b0, 1'b0, dummy);
        push_st(w3 + 9,  2, 4'b1000, 4'b0000);
        push_st(w3 + 12, 0, 4'b1111, 4'b1110);
        push_st(w3 + 12, 1, 4'b1111, 4'b1100);
        push_st(w3 + 12, 3, 4'b0001, 4'b0001);

        // Mid-count reset with pending and overrun set.
        wait_until(w3 + 12);
        rr = cyc + 1;
        push_st(rr, 0, 4'b1111, 4'b0000);
        push_st(rr, 1, 4'b1111, 4'b0000);
        push_st(rr, 2, 4'b1111, 4'b0001);
        push_st(rr, 3, 4'b0001, 4'b0000);
        tq[0].push_back(rr + 40000);
        push_st(rr + 39999, 0, 4'b1111, 4'b0000);
        push_st(rr + 40000, 0, 4'b1111, 4'b0001);
        push_st(rr + 40001, 0, 4'b1111, 4'b0001);
        push_st(rr + 40001, 3, 4'b0001, 4'b0001);
        reset_n_s = 1'b0;
        @(negedge clk_s);
        reset_n_s = 1'b1;
        wait_until(rr + 40010);

        for (int ch = 0; ch < 4; ch++) begin
            while (tq[ch].size() > 0) begin
                checks++;
                errors++;
                $display("FAIL tick_missing ch%0d: got no tick, want tick at cyc %0d", ch, tq[ch].pop_front());
            end
        end
        while (sq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s unchecked: got no sample, want check at cyc %0d", kind_name(sq[0].kind), sq[0].cyc);
            void'(sq.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
